// File: rtl/ecc_secded_stream.sv
// SECDED decoder stage for a valid/ready codeword stream: one registered output
// stage with single-error correction, double-error detection and event counters.
package ecc_pkg;

   function automatic int get_parity_width(int data_width);
      for (int r = 1; r < 32; r++) begin
         if ((1 << r) >= data_width + r + 1) return r;
      end
      return 32;
   endfunction

   // Hamming index that carries data bit k (non-power-of-two positions, ascending).
   function automatic int get_data_pos(int k);
      int cnt;
      cnt = -1;
      for (int p = 1; p < (1 << 30); p++) begin
         if ((p & (p - 1)) != 0) begin
            cnt++;
            if (cnt == k) return p;
         end
      end
      return 0;
   endfunction

endpackage

module ecc_secded_stream #(
   parameter int DataWidth = 64,
   parameter int CntWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth+ecc_pkg::get_parity_width(DataWidth):0] in_cw_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o,
   output logic [ecc_pkg::get_parity_width(DataWidth)-1:0] out_syndrome_o,
   output logic                 out_single_err_o,
   output logic                 out_double_err_o,
   input  logic                 clear_i,
   output logic [CntWidth-1:0]  single_cnt_o,
   output logic [CntWidth-1:0]  double_cnt_o
);

   localparam int HamWidth = ecc_pkg::get_parity_width(DataWidth);
   localparam int ParWidth = HamWidth + 1;
   localparam int CwWidth  = DataWidth + ParWidth;
   localparam logic [HamWidth:0]   CwLimit = (HamWidth + 1)'(CwWidth);
   localparam logic [CntWidth-1:0] CntMax  = '1;

   logic [HamWidth-1:0]  syndrome;
   logic                 parity;
   logic                 syn_in_range;
   logic                 single_err;
   logic                 double_err;
   logic                 accept;
   logic [DataWidth-1:0] data_fix;

   logic                 out_valid_reg;
   logic [DataWidth-1:0] out_data_reg;
   logic [HamWidth-1:0]  out_syn_reg;
   logic                 single_reg;
   logic                 double_reg;

   logic [1:0]           cnt_event;
   logic [CntWidth-1:0]  cnt_reg  [2];
   logic [CntWidth-1:0]  cnt_next [2];

   always_comb begin
      syndrome = '0;
      for (int i = 1; i < CwWidth; i++) begin
         if (in_cw_i[i]) syndrome = syndrome ^ HamWidth'(i);
      end
   end

   assign parity       = ^in_cw_i;
   assign syn_in_range = ({1'b0, syndrome} < CwLimit);
   assign single_err   = parity & syn_in_range;
   assign double_err   = (parity & ~syn_in_range) | (~parity & (syndrome != '0));

   // Only a single error can flip a data bit; on a double error data passes through raw.
   for (genvar gi = 0; gi < DataWidth; gi++) begin : g_data
      localparam int Pos = ecc_pkg::get_data_pos(gi);
      assign data_fix[gi] = in_cw_i[Pos] ^ (single_err && (syndrome == HamWidth'(Pos)));
   end

   assign in_ready_o = ~out_valid_reg | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_syn_reg   <= '0;
         single_reg    <= 1'b0;
         double_reg    <= 1'b0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= data_fix;
         out_syn_reg   <= syndrome;
         single_reg    <= single_err;
         double_reg    <= double_err;
      end else if (out_ready_i) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign cnt_event[0] = accept & single_err;
   assign cnt_event[1] = accept & double_err;

   // A clear coinciding with an event keeps that event as the new count of 1.
   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
         cnt_next[gi] = cnt_reg[gi];
         if (clear_i) begin
            cnt_next[gi] = cnt_event[gi] ? CntWidth'(1) : '0;
         end else if (cnt_event[gi] && (cnt_reg[gi] != CntMax)) begin
            cnt_next[gi] = cnt_reg[gi] + 1'b1;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) cnt_reg[gi] <= '0;
         else         cnt_reg[gi] <= cnt_next[gi];
      end
   end

   assign out_valid_o      = out_valid_reg;
   assign out_data_o       = out_data_reg;
   assign out_syndrome_o   = out_syn_reg;
   assign out_single_err_o = single_reg;
   assign out_double_err_o = double_reg;
   assign single_cnt_o     = cnt_reg[0];
   assign double_cnt_o     = cnt_reg[1];

endmodule

// File: tb/tb_ecc_secded_stream.sv
// Scoreboard bench for ecc_secded_stream at DataWidth=8, CntWidth=2 (13-bit codewords)
// using hand-encoded codewords.
module tb_ecc_secded_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] in_cw;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [3:0]  out_syn;
   logic        out_se;
   logic        out_de;
   logic        clear;
   logic [1:0]  single_cnt;
   logic [1:0]  double_cnt;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] s;
      logic       se;
      logic       de;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   ecc_secded_stream #(.DataWidth(8), .CntWidth(2)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .in_valid_i      (in_valid),
      .in_ready_o      (in_ready),
      .in_cw_i         (in_cw),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .out_data_o      (out_data),
      .out_syndrome_o  (out_syn),
      .out_single_err_o(out_se),
      .out_double_err_o(out_de),
      .clear_i         (clear),
      .single_cnt_o    (single_cnt),
      .double_cnt_o    (double_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(logic [7:0] d, logic [3:0] s, logic se, logic de);
      exp_t e;
      e.d = d; e.s = s; e.se = se; e.de = de;
      return e;
   endfunction

   // Entered and left at posedge+1; pushes the expectation once the word is accepted.
   task automatic send(logic [12:0] cw, exp_t e);
      bit hs;
      hs = 1'b0;
      in_valid = 1'b1;
      in_cw = cw;
      for (int k = 0; k < 50 && !hs; k++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
      end
      if (hs) sb.push_back(e);
      chk("send_handshake", 32'(hs), 32'd1);
      #1;
      in_valid = 1'b0;
      $display("sent cw=%h exp data=%h syn=%0d se=%b de=%b accepted=%0d", cw, e.d, e.s, e.se, e.de, hs);
   endtask

   // Monitor: pops on each output handshake and checks stall stability.
   initial begin
      exp_t e;
      exp_t held;
      bit   stall_prev;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stall_prev && out_valid) begin
               chk("stall_data", 32'(out_data), 32'(held.d));
               chk("stall_syn",  32'(out_syn),  32'(held.s));
               chk("stall_se",   32'(out_se),   32'(held.se));
               chk("stall_de",   32'(out_de),   32'(held.de));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  chk("out_data",   32'(out_data), 32'(e.d));
                  chk("out_syn",    32'(out_syn),  32'(e.s));
                  chk("out_single", 32'(out_se),   32'(e.se));
                  chk("out_double", 32'(out_de),   32'(e.de));
                  $display("recv data=%h syn=%0d se=%b de=%b", out_data, out_syn, out_se, out_de);
               end
            end
            stall_prev = out_valid && !out_ready;
            held = mk(out_data, out_syn, out_se, out_de);
         end
      end
   end

   initial begin
      int c0;
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_cw = 13'h1EEE;
      out_ready = 1'b1;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid",   32'(out_valid), 32'd0);
      chk("rst_data",    32'(out_data), 32'd0);
      chk("rst_syn",     32'(out_syn), 32'd0);
      chk("rst_flags",   32'({out_se, out_de}), 32'd0);
      chk("rst_cnts",    32'({single_cnt, double_cnt}), 32'd0);
      chk("rst_ready",   32'(in_ready), 32'd1);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Clean 0xA5, then output must be valid one cycle after acceptance.
      send(13'h144E, mk(8'hA5, 4'd0, 1'b0, 1'b0));
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      send(13'h146E, mk(8'hA5, 4'd5, 1'b1, 1'b0));
      chk("single_cnt_1", 32'(single_cnt), 32'd1);
      send(13'h1406, mk(8'hA0, 4'd5, 1'b0, 1'b1));
      chk("double_cnt_1", 32'(double_cnt), 32'd1);
      send(13'h144F, mk(8'hA5, 4'd0, 1'b1, 1'b0));
      chk("single_cnt_2", 32'(single_cnt), 32'd2);
      send(13'h154E, mk(8'hA5, 4'd8, 1'b1, 1'b0));
      chk("single_cnt_3", 32'(single_cnt), 32'd3);
      send(13'h155C, mk(8'hA5, 4'd13, 1'b0, 1'b1));
      chk("double_cnt_2", 32'(double_cnt), 32'd2);

      // Backpressure: hold one word for three cycles, then stream three more.
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(13'h000F, mk(8'h01, 4'd0, 1'b0, 1'b0));
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      c0 = cyc;
      send(13'h1111, mk(8'h80, 4'd0, 1'b0, 1'b0));
      send(13'h1EEE, mk(8'hFF, 4'd0, 1'b0, 1'b0));
      send(13'h0000, mk(8'h00, 4'd0, 1'b0, 1'b0));
      chk("b2b_cycles", 32'(cyc - c0), 32'd3);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_drained", 32'(sb.size()), 32'd0);

      // Counters: clear, saturate, clear with coincident event, clear alone.
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clr_single", 32'(single_cnt), 32'd0);
      chk("clr_double", 32'(double_cnt), 32'd0);
      for (int k = 0; k < 5; k++) begin
         send(13'h146E, mk(8'hA5, 4'd5, 1'b1, 1'b0));
         chk("sat_single", 32'(single_cnt), 32'((k < 3) ? k + 1 : 3));
      end
      clear = 1'b1;
      send(13'h146E, mk(8'hA5, 4'd5, 1'b1, 1'b0));
      clear = 1'b0;
      chk("clr_with_event", 32'(single_cnt), 32'd1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clr_alone", 32'(single_cnt), 32'd0);

      // Reset while a word is stalled in the output stage discards it.
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(13'h1EEE, mk(8'hFF, 4'd0, 1'b0, 1'b0));
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      sb.delete();
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(out_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_secded_stream.md
ECC_SECDED_STREAM -- requirements
Module: ecc_secded_stream

Interface
REQ-001 SHALL have parameter DataWidth, default 64, meaning protected payload width in bits (min 1).
REQ-002 SHALL have parameter CntWidth, default 16, meaning width of each error event counter (min 1).
REQ-003 SHALL derive local HamWidth = ecc_pkg::get_parity_width(DataWidth), ParWidth = HamWidth+1, CwWidth = DataWidth+ParWidth.
REQ-004 SHALL provide ports as follows:
  clk_i  in  1  clock; one clock domain, all logic on rising edge
  rst_ni  in  1  reset; asynchronous, active-low
  in_valid_i  in  1  input codeword valid
  in_ready_o  out  1  input accepted when valid and ready both high
  in_cw_i  in  CwWidth  received codeword
  out_valid_o  out  1  output valid
  out_ready_i  in  1  downstream ready
  out_data_o  out  DataWidth  corrected payload
  out_syndrome_o  out  HamWidth  Hamming syndrome of that word
  out_single_err_o  out  1  single-bit error corrected
  out_double_err_o  out  1  uncorrectable error detected
  clear_i  in  1  synchronous clear of both counters
  single_cnt_o  out  CntWidth  saturating count of single errors
  double_cnt_o  out  CntWidth  saturating count of uncorrectable errors

Function
REQ-005 SHALL use codeword layout: bit 0 = overall even parity; bits 1..CwWidth-1 = Hamming positions, power-of-two positions are check bits, remaining positions carry data bits 0..DataWidth-1 in ascending order.
REQ-006 SHALL compute syndrome s = XOR of indices i (1..CwWidth-1) with cw[i]=1, and p = XOR of all CwWidth bits.
REQ-007 SHALL classify: s=0,p=0 -> clean; p=1 and s<CwWidth -> single error at index s (s=0 means parity bit 0), flip that bit; s!=0,p=0 -> double error; p=1 and s>=CwWidth -> double error.
REQ-008 SHALL output data uncorrected (as received) on a double error.
REQ-009 SHALL assert out_single_err_o for a single error in a check or parity position, with out_data_o unchanged.
REQ-010 SHALL never assert out_single_err_o and out_double_err_o together.
REQ-011 SHALL register all results in one output stage: latency exactly 1 cycle from input handshake to out_valid_o.
REQ-012 SHALL drive in_ready_o = !out_valid_o | out_ready_i (combinational, no dependency on in_valid_i).
REQ-013 SHALL hold out_data_o, out_syndrome_o and error flags stable while out_valid_o=1 and out_ready_i=0.
REQ-014 SHALL clear out_valid_o on output handshake when no new input is accepted in that cycle; SHALL sustain one word per cycle when both sides stay ready.
REQ-015 SHALL increment single_cnt_o / double_cnt_o in the cycle the classifying word is loaded into the output stage (input handshake edge).
REQ-016 SHALL saturate counters at 2^CntWidth-1; no wrap-around.
REQ-017 SHALL, when clear_i and an increment coincide, load the counter with 1 (event not lost); clear_i alone loads 0.
REQ-018 SHALL keep output register contents unchanged when no input handshake occurs (no spurious flag toggling).

Reset
REQ-019 SHALL, on rst_ni low, asynchronously drive out_valid_o=0, out_data_o=0, out_syndrome_o=0, both error flags=0, both counters=0.
REQ-020 SHALL drive in_ready_o=1 while in reset and in the first cycle after release.
REQ-021 SHALL discard a word held in the output stage when reset asserts mid-transfer; no output handshake after release until a new input is accepted.

Verification (DataWidth=8, CntWidth=2: HamWidth=4, CwWidth=13)
REQ-022 SHALL cover reset: rst_ni low with in_valid_i=1 -> all outputs 0, in_ready_o=1, counters 0.
REQ-023 SHALL cover clean word: encoded 0xA5 accepted at cycle N -> cycle N+1 out_valid_o=1, out_data_o=0xA5, syndrome 0, flags 0.
REQ-024 SHALL cover single error: encoded 0xA5 with bit 5 flipped -> out_data_o=0xA5, syndrome 5, single_err=1, single_cnt_o=1.
REQ-025 SHALL cover double error: encoded 0xA5 with bits 3 and 6 flipped -> double_err=1, syndrome 5, data as received, double_cnt_o=1.
REQ-026 SHALL cover backpressure: out_ready_i=0 for 3 cycles with out_valid_o=1 -> in_ready_o=0, outputs stable; 4 back-to-back words delivered in order, none lost or duplicated.
REQ-027 SHALL cover counters: 5 single-error words -> single_cnt_o=3 (saturated); clear_i with a coincident single error -> 1; clear_i alone -> 0.
